// File: rtl/mem_wb_lanes_if.sv
// rtl/mem_wb_lanes_if.sv - MEM->WB lane bundle: stage controls, lane writes in, registered writes/history out
interface mem_wb_lanes_if #(
  parameter int LANES      = 2,
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 7,
  parameter int STALL_W    = 13,
  parameter int HIST_DEPTH = 2,
  parameter int CNT_W      = 16
);
  logic                                flush;
  logic [0:STALL_W-1]                  stall;
  logic [LANES*ADDR_W-1:0]             in_addr;
  logic [LANES-1:0]                    in_wreg;
  logic [LANES*DATA_W-1:0]             in_data;
  logic [LANES*ADDR_W-1:0]             out_addr;
  logic [LANES-1:0]                    out_wreg;
  logic [LANES*DATA_W-1:0]             out_data;
  logic [HIST_DEPTH*LANES*ADDR_W-1:0]  hist_addr;
  logic [HIST_DEPTH*LANES-1:0]         hist_wreg;
  logic [HIST_DEPTH*LANES*DATA_W-1:0]  hist_data;
  logic                                coll_pulse;
  logic [CNT_W-1:0]                    coll_count;

  modport master (
    output flush, stall, in_addr, in_wreg, in_data,
    input  out_addr, out_wreg, out_data, hist_addr, hist_wreg, hist_data,
           coll_pulse, coll_count
  );

  modport slave (
    input  flush, stall, in_addr, in_wreg, in_data,
    output out_addr, out_wreg, out_data, hist_addr, hist_wreg, hist_data,
           coll_pulse, coll_count
  );
endinterface

// File: rtl/mem_wb_lanes.sv
// rtl/mem_wb_lanes.sv - N-lane MEM->WB register with flush, write-collision resolution and retired-write history
module mem_wb_lanes #(
  parameter int LANES      = 2,
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 7,
  parameter int STALL_W    = 13,
  parameter int STAGE_IDX  = 11,
  parameter int HIST_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_wb_lanes_if.slave bus
);
  localparam int AW = LANES * ADDR_W;
  localparam int DW = LANES * DATA_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [AW-1:0]            out_addr_q, out_addr_d;
  logic [LANES-1:0]         out_wreg_q, out_wreg_d;
  logic [DW-1:0]            out_data_q, out_data_d;
  logic [HIST_DEPTH*AW-1:0] hist_addr_q, hist_addr_d;
  logic [HIST_DEPTH*LANES-1:0] hist_wreg_q, hist_wreg_d;
  logic [HIST_DEPTH*DW-1:0] hist_data_q, hist_data_d;
  logic                     coll_pulse_q, coll_pulse_d;
  logic [CNT_W-1:0]         coll_count_q, coll_count_d;

  logic             s_stop;
  logic             t_stop;
  logic [LANES-1:0] wreg_res;
  logic             any_coll;

  // Same-address writers: the higher lane index keeps its write enable.
  always_comb begin
    wreg_res = bus.in_wreg;
    any_coll = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (bus.in_wreg[i] && bus.in_wreg[j] &&
            (bus.in_addr[i*ADDR_W +: ADDR_W] == bus.in_addr[j*ADDR_W +: ADDR_W])) begin
          wreg_res[i] = 1'b0;
          any_coll    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    s_stop       = bus.stall[STAGE_IDX];
    t_stop       = bus.stall[STAGE_IDX+1];
    out_addr_d   = out_addr_q;
    out_wreg_d   = out_wreg_q;
    out_data_d   = out_data_q;
    hist_addr_d  = hist_addr_q;
    hist_wreg_d  = hist_wreg_q;
    hist_data_d  = hist_data_q;
    coll_pulse_d = 1'b0;
    coll_count_d = coll_count_q;

    if (bus.flush || !t_stop) begin
      for (int h = HIST_DEPTH - 1; h > 0; h--) begin
        hist_addr_d[h*AW +: AW]       = hist_addr_q[(h-1)*AW +: AW];
        hist_wreg_d[h*LANES +: LANES] = hist_wreg_q[(h-1)*LANES +: LANES];
        hist_data_d[h*DW +: DW]       = hist_data_q[(h-1)*DW +: DW];
      end
      hist_addr_d[0 +: AW]    = out_addr_q;
      hist_wreg_d[0 +: LANES] = out_wreg_q;
      hist_data_d[0 +: DW]    = out_data_q;
    end

    if (bus.flush || (s_stop && !t_stop)) begin
      out_addr_d = '0;
      out_wreg_d = '0;
      out_data_d = '0;
    end else if (!t_stop) begin
      out_addr_d   = bus.in_addr;
      out_wreg_d   = wreg_res;
      out_data_d   = bus.in_data;
      coll_pulse_d = any_coll;
      if (any_coll && (coll_count_q != CNT_MAX)) begin
        coll_count_d = coll_count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_addr_q   <= '0;
      out_wreg_q   <= '0;
      out_data_q   <= '0;
      hist_addr_q  <= '0;
      hist_wreg_q  <= '0;
      hist_data_q  <= '0;
      coll_pulse_q <= 1'b0;
      coll_count_q <= '0;
    end else begin
      out_addr_q   <= out_addr_d;
      out_wreg_q   <= out_wreg_d;
      out_data_q   <= out_data_d;
      hist_addr_q  <= hist_addr_d;
      hist_wreg_q  <= hist_wreg_d;
      hist_data_q  <= hist_data_d;
      coll_pulse_q <= coll_pulse_d;
      coll_count_q <= coll_count_d;
    end
  end

  assign bus.out_addr   = out_addr_q;
  assign bus.out_wreg   = out_wreg_q;
  assign bus.out_data   = out_data_q;
  assign bus.hist_addr  = hist_addr_q;
  assign bus.hist_wreg  = hist_wreg_q;
  assign bus.hist_data  = hist_data_q;
  assign bus.coll_pulse = coll_pulse_q;
  assign bus.coll_count = coll_count_q;
endmodule

// File: tb/tb_mem_wb_lanes.sv
// tb/tb_mem_wb_lanes.sv - self-checking bench for mem_wb_lanes against a queue-based reference model
module tb_mem_wb_lanes;
  localparam int LANES      = 2;
  localparam int DATA_W     = 128;
  localparam int ADDR_W     = 7;
  localparam int STALL_W    = 13;
  localparam int STAGE_IDX  = 11;
  localparam int HIST_DEPTH = 2;
  localparam int CNT_W      = 16;
  localparam int CNT_W_S    = 2;

  typedef struct packed {
    logic [LANES*ADDR_W-1:0] addr;
    logic [LANES-1:0]        wreg;
    logic [LANES*DATA_W-1:0] data;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic                    flush = 1'b0;
  logic [0:STALL_W-1]      stall = '0;
  logic [LANES*ADDR_W-1:0] in_addr = '0;
  logic [LANES-1:0]        in_wreg = '0;
  logic [LANES*DATA_W-1:0] in_data = '0;

  int total = 0;
  int bad   = 0;

  rec_t m_out;
  rec_t m_hist[$];
  bit   m_pulse;
  int   m_cnt;
  int   m_cnt_s;

  always #5 clk = ~clk;

  mem_wb_lanes_if #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STALL_W(STALL_W),
                    .HIST_DEPTH(HIST_DEPTH), .CNT_W(CNT_W)) mif ();
  mem_wb_lanes_if #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STALL_W(STALL_W),
                    .HIST_DEPTH(HIST_DEPTH), .CNT_W(CNT_W_S)) sif ();

  assign mif.flush = flush;   assign sif.flush = flush;
  assign mif.stall = stall;   assign sif.stall = stall;
  assign mif.in_addr = in_addr; assign sif.in_addr = in_addr;
  assign mif.in_wreg = in_wreg; assign sif.in_wreg = in_wreg;
  assign mif.in_data = in_data; assign sif.in_data = in_data;

  mem_wb_lanes #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STALL_W(STALL_W),
                 .STAGE_IDX(STAGE_IDX), .HIST_DEPTH(HIST_DEPTH), .CNT_W(CNT_W))
    dut (.clk(clk), .rst(rst), .bus(mif));

  mem_wb_lanes #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STALL_W(STALL_W),
                 .STAGE_IDX(STAGE_IDX), .HIST_DEPTH(HIST_DEPTH), .CNT_W(CNT_W_S))
    dut_s (.clk(clk), .rst(rst), .bus(sif));

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = '0;
    m_hist.delete();
    for (int h = 0; h < HIST_DEPTH; h++) m_hist.push_back('0);
    m_pulse = 1'b0;
    m_cnt   = 0;
    m_cnt_s = 0;
  endtask

  // One clock edge of the register as seen from the behaviour rules.
  task automatic model_edge();
    bit s_b, t_b, lost, coll;
    s_b = stall[STAGE_IDX];
    t_b = stall[STAGE_IDX+1];
    if (flush || !t_b) begin
      m_hist.push_front(m_out);
      void'(m_hist.pop_back());
    end
    m_pulse = 1'b0;
    if (flush || (s_b && !t_b)) begin
      m_out = '0;
    end else if (!t_b) begin
      coll = 1'b0;
      m_out.addr = in_addr;
      m_out.data = in_data;
      for (int i = 0; i < LANES; i++) begin
        lost = 1'b0;
        for (int j = i + 1; j < LANES; j++)
          if (in_wreg[i] && in_wreg[j] && in_addr[i*ADDR_W +: ADDR_W] == in_addr[j*ADDR_W +: ADDR_W])
            lost = 1'b1;
        m_out.wreg[i] = in_wreg[i] & ~lost;
        coll |= lost;
      end
      if (coll) begin
        m_pulse = 1'b1;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (m_cnt_s < (1 << CNT_W_S) - 1) m_cnt_s++;
      end
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, " out_addr"}, mif.out_addr, m_out.addr);
    chk({ph, " out_wreg"}, mif.out_wreg, m_out.wreg);
    chk({ph, " out_data"}, mif.out_data, m_out.data);
    for (int h = 0; h < HIST_DEPTH; h++) begin
      chk($sformatf("%s hist%0d_addr", ph, h), mif.hist_addr[h*LANES*ADDR_W +: LANES*ADDR_W], m_hist[h].addr);
      chk($sformatf("%s hist%0d_wreg", ph, h), mif.hist_wreg[h*LANES +: LANES], m_hist[h].wreg);
      chk($sformatf("%s hist%0d_data", ph, h), mif.hist_data[h*LANES*DATA_W +: LANES*DATA_W], m_hist[h].data);
    end
    chk({ph, " coll_pulse"}, mif.coll_pulse, m_pulse);
    chk({ph, " coll_count"}, mif.coll_count, m_cnt[CNT_W-1:0]);
    chk({ph, " sat_count"}, sif.coll_count, m_cnt_s[CNT_W_S-1:0]);
    chk({ph, " sat_wreg"}, sif.out_wreg, m_out.wreg);
  endtask

  task automatic edge_chk(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ph);
  endtask

  task automatic set_stall(input bit s_b, input bit t_b);
    for (int k = 0; k < STALL_W; k++) stall[k] = 1'($urandom);
    stall[STAGE_IDX]   = s_b;
    stall[STAGE_IDX+1] = t_b;
  endtask

  task automatic set_lanes(input int a0, input bit w0, input logic [DATA_W-1:0] d0,
                           input int a1, input bit w1, input logic [DATA_W-1:0] d1);
    in_addr = {ADDR_W'(a1), ADDR_W'(a0)};
    in_wreg = {w1, w0};
    in_data = {d1, d0};
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [DATA_W-1:0] da, db;

  initial begin
    model_reset();
    set_stall(1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Plain capture, then history shift.
    da = {32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 32'hAAAA_0004};
    db = {32'hBBBB_0001, 32'hBBBB_0002, 32'hBBBB_0003, 32'hBBBB_0004};
    set_lanes(5, 1'b1, da, 9, 1'b1, db);
    edge_chk("cap");
    chk("cap addr const", mif.out_addr, {7'd9, 7'd5});
    chk("cap wreg const", mif.out_wreg, 2'b11);
    chk("cap data const", mif.out_data, {db, da});
    set_lanes(1, 1'b1, rnd_data(), 2, 1'b0, rnd_data());
    edge_chk("cap2");
    chk("hist0 addr const", mif.hist_addr[0 +: LANES*ADDR_W], {7'd9, 7'd5});
    chk("hist0 data const", mif.hist_data[0 +: LANES*DATA_W], {db, da});

    // Upstream stop -> bubble.
    set_stall(1'b1, 1'b0);
    set_lanes(3, 1'b1, rnd_data(), 4, 1'b1, rnd_data());
    edge_chk("bubble");
    chk("bubble wreg const", mif.out_wreg, 2'b00);

    // This-stage stop: hold for three cycles while inputs churn.
    for (int c = 0; c < 3; c++) begin
      set_stall(1'($urandom), 1'b1);
      set_lanes($urandom_range(0, 3), 1'b1, rnd_data(), $urandom_range(0, 3), 1'b1, rnd_data());
      edge_chk($sformatf("hold%0d", c));
    end

    // Collision: both lanes to address 5.
    set_stall(1'b0, 1'b0);
    set_lanes(5, 1'b1, rnd_data(), 5, 1'b1, rnd_data());
    edge_chk("coll");
    chk("coll wreg const", mif.out_wreg, 2'b10);
    chk("coll pulse const", mif.coll_pulse, 1'b1);
    chk("coll count const", mif.coll_count, 16'd1);
    set_lanes(0, 1'b1, rnd_data(), 0, 1'b0, rnd_data());
    edge_chk("coll off");
    chk("coll pulse drop", mif.coll_pulse, 1'b0);
    for (int c = 0; c < 5; c++) begin
      set_lanes(0, 1'b1, rnd_data(), 0, 1'b1, rnd_data());
      edge_chk($sformatf("coll_sat%0d", c));
    end
    chk("sat count const", sif.coll_count, 2'd3);
    chk("coll count six", mif.coll_count, 16'd6);

    // Flush overrides this-stage stop.
    flush = 1'b1;
    set_stall(1'b0, 1'b1);
    edge_chk("flush");
    chk("flush wreg const", mif.out_wreg, 2'b00);
    chk("flush pulse const", mif.coll_pulse, 1'b0);
    flush = 1'b0;

    // Fill history with live writes, then reset between edges.
    set_stall(1'b0, 1'b0);
    set_lanes(1, 1'b1, rnd_data(), 2, 1'b1, rnd_data());
    edge_chk("fill0");
    set_lanes(3, 1'b1, rnd_data(), 4, 1'b1, rnd_data());
    edge_chk("fill1");
    chk("fill wreg const", mif.out_wreg, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async rst");
    @(posedge clk);
    #1;
    check_all("rst hold");
    rst = 1'b0;

    // Random traffic on a small address pool so collisions are frequent.
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 7) == 0);
      set_stall($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      set_lanes($urandom_range(0, 3), 1'($urandom), rnd_data(),
                $urandom_range(0, 3), 1'($urandom), rnd_data());
      edge_chk($sformatf("rnd%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
